// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: state encodings and
// channel bookkeeping used by the top level and its dwell counter.
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  localparam int          NCH     = 4;
  localparam logic [1:0]  LAST_CH = 2'd3;

endpackage

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Dwell timer: counts cycles spent on one mux channel and flags the last one
// (tc) so the sequencer knows when to sample y and advance.
module mux_scan_sequencer_dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select through channels 0..3, holding each for DWELL cycles,
// and assembles the four end-of-dwell samples of y into a 4-bit result.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           y_in,
  output logic [1:0]     sel,
  output logic           busy,
  output logic           done,
  output logic           valid,
  output logic [NCH-1:0] result
);

  scan_state_t    state_reg;
  logic [1:0]     sel_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           valid_reg;
  logic [NCH-1:0] shadow_reg;
  logic [NCH-1:0] shadow_next;
  logic [NCH-1:0] result_reg;

  logic tc;
  logic cnt_en;
  logic cnt_clr;
  logic sample_strobe;

  // An abort wins over a coinciding terminal count, so no sample is taken then.
  assign cnt_en        = (state_reg == SCAN);
  assign cnt_clr       = (state_reg != SCAN) || tc || abort;
  assign sample_strobe = (state_reg == SCAN) && tc && !abort;

  mux_scan_sequencer_dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_shadow
      localparam logic [1:0] CH = 2'(gi);
      assign shadow_next[gi] = (sample_strobe && (sel_reg == CH)) ? y_in : shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sel_reg    <= 2'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      shadow_reg <= '0;
      result_reg <= '0;
    end else begin
      shadow_reg <= shadow_next;
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start && !abort) begin
            state_reg <= SCAN;
            sel_reg   <= 2'd0;
            busy_reg  <= 1'b1;
            valid_reg <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            busy_reg  <= 1'b0;
          end else if (tc) begin
            if (sel_reg == LAST_CH) begin
              state_reg <= DONE;
              sel_reg   <= 2'd0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              sel_reg <= sel_reg + 2'd1;
            end
          end
        end
        DONE: begin
          // shadow already holds the last channel, captured on the edge into DONE.
          done_reg   <= 1'b0;
          result_reg <= shadow_reg;
          valid_reg  <= 1'b1;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          sel_reg   <= 2'd0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = sel_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign valid  = valid_reg;
  assign result = result_reg;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Sequencer that sits around the 4:1 `multiplexer` and is both its upstream and downstream stage. It drives the mux select `s` and walks it through channels 0..3. It holds each channel for a programmable dwell time and samples mux output `y` at the end of each dwell. The four samples are assembled into a 4-bit result word, with a start/busy/done handshake toward the controlling logic.

Parameters:
- DWELL, 4, cycles each channel is held before sampling; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- abort  input  1  cancel an in-progress scan.
- y_in  input  1  mux output `y`.
- sel  output  2  drives mux select `s`.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when a scan completes.
- valid  output  1  result holds a completed scan.
- result  output  4  result[n] = y_in sampled with sel==n.

Behaviour:
- Reset (rst=1 at a clk edge) takes effect at that edge and is highest priority:
  - state=IDLE; sel=0, busy=0, done=0, valid=0, result=0, dwell counter=0, shadow=0.
- Reset mid-scan discards partial samples; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - sel=0, busy=0.
  - start=1 and abort=0 at an edge -> SCAN; sel=0, counter=0, valid cleared to 0.
  - start=1 with abort=1 in the same cycle -> stay IDLE; valid unchanged.
- SCAN:
  - busy=1; counter increments each cycle.
  - In the cycle where counter==DWELL-1, the edge captures y_in into shadow[sel] and resets counter to 0.
  - At that edge: if sel<3, sel increments; if sel==3, next state is DONE and sel returns to 0.
  - DWELL=1: one sample per cycle, sel steps every cycle.
- DONE:
  - Lasts exactly one cycle: busy=0, done=1.
  - The edge leaving DONE loads result<=shadow and sets valid=1, then -> IDLE.
  - result and valid become visible the cycle after done.
- Timing: start accepted at edge E0 -> busy high for cycles E0+1 .. E0+4*DWELL -> done high in cycle E0+4*DWELL+1 -> result/valid updated from E0+4*DWELL+2.
- start while in SCAN or DONE is ignored; it is not queued.
- abort:
  - In SCAN: next edge -> IDLE; sel=0, busy=0; result keeps its previous value; valid stays 0; no done pulse.
  - In DONE: ignored; the scan completes normally.
  - In IDLE: no effect.
- result changes only on the DONE->IDLE edge or on reset; it is stable at all other times.
- sel is registered, glitch-free, and changes only on clock edges.
- The mux is combinational, so y_in is assumed settled within one cycle of a sel change; DWELL>=1 guarantees this.

Decomposition:
- Shared include file mux_scan_defs.vh holds:
  - state encodings: IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - channel count localparam NCH=4;
  - last channel index LAST_CH=2'd3.
- One sub-module is natural: dwell_counter (CNT_W-bit counter with clear and terminal-count output tc = (count==DWELL-1)).
- State register, sel, shadow and result logic live in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles mid-scan -> next cycle sel=0, busy=0, done=0, valid=0, result=4'b0000; no done pulse afterward.
- Basic scan, DWELL=4, mux i=4'b1010:
  - start pulse at edge 0 -> sel = 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3 over cycles 1..16;
  - done=1 in cycle 17;
  - result=4'b1010 and valid=1 from cycle 18.
- DWELL=1, i=4'b0110:
  - start -> sel steps 0,1,2,3 on consecutive cycles;
  - done in cycle 5; result=4'b0110.
- Abort: start with i=4'b1111 after a completed scan with result 4'b1010; abort=1 in cycle 6 -> IDLE next cycle, busy=0, no done, result stays 4'b1010, valid=0.
- Ignored/simultaneous events:
  - start pulsed during SCAN and during the DONE cycle -> exactly one done pulse and no second scan;
  - start=1 with abort=1 in IDLE -> remains IDLE, busy=0.
- Input change mid-scan: i changed from 4'b0000 to 4'b1111 while sel==2 (before its sample edge) -> result=4'b1100.
